// File: rtl/vga_rx_pkg.sv
// Shared definitions for the VGA receive decoder: 640x480@60 timing, lock-FSM
// encoding, the recovered-pixel payload and reference RGB565 colours.
package vga_rx_pkg;

  localparam int unsigned CNT_W = 10;
  localparam int unsigned RGB_W = 16;

  localparam logic [CNT_W-1:0] H_SYNC  = 10'd96;
  localparam logic [CNT_W-1:0] H_BACK  = 10'd48;
  localparam logic [CNT_W-1:0] H_VALID = 10'd640;
  localparam logic [CNT_W-1:0] H_TOTAL = 10'd800;
  localparam logic [CNT_W-1:0] V_SYNC  = 10'd2;
  localparam logic [CNT_W-1:0] V_BACK  = 10'd33;
  localparam logic [CNT_W-1:0] V_VALID = 10'd480;
  localparam logic [CNT_W-1:0] V_TOTAL = 10'd525;

  localparam logic [CNT_W-1:0] H_ACT_START = CNT_W'(H_SYNC + H_BACK);
  localparam logic [CNT_W-1:0] H_ACT_END   = CNT_W'(H_SYNC + H_BACK + H_VALID - 10'd1);
  localparam logic [CNT_W-1:0] V_ACT_START = CNT_W'(V_SYNC + V_BACK);
  localparam logic [CNT_W-1:0] V_ACT_END   = CNT_W'(V_SYNC + V_BACK + V_VALID - 10'd1);

  typedef enum logic [1:0] {
    UNLOCKED = 2'd0,
    ACQUIRE  = 2'd1,
    LOCKED   = 2'd2
  } state_e;

  typedef struct packed {
    logic             valid;
    logic             sof;
    logic [CNT_W-1:0] x;
    logic [CNT_W-1:0] y;
    logic [RGB_W-1:0] data;
  } pix_t;

  localparam logic [RGB_W-1:0] RGB_BLACK  = 16'h0000;
  localparam logic [RGB_W-1:0] RGB_RED    = 16'hF800;
  localparam logic [RGB_W-1:0] RGB_ORANGE = 16'hFC00;
  localparam logic [RGB_W-1:0] RGB_WHITE  = 16'hFFFF;

endpackage

// File: rtl/vga_sync_edge.sv
// Registers one sync line, normalises its polarity and flags a leading edge
// relative to the level captured at the last smp_i strobe.
module vga_sync_edge #(
  parameter logic POL = 1'b1
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic sync_i,
  input  logic smp_i,
  output logic lead_edge_c_o
);
  import vga_rx_pkg::*;

  logic lvl_q;
  logic prev_q;

  // smp_i tied high gives a plain clock-to-clock edge; strobed, it compares
  // against the level seen at the previous strobe.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      lvl_q  <= 1'b0;
      prev_q <= 1'b0;
    end else begin
      lvl_q <= (sync_i == POL);
      if (smp_i) prev_q <= lvl_q;
    end
  end

  assign lead_edge_c_o = lvl_q & ~prev_q;

endmodule

// File: rtl/vga_rx_decoder.sv
// VGA sink: recovers pixel coordinates and colour from a raw sync/RGB565
// stream, tracks timing lock and pulses timing_err on violations while locked.
module vga_rx_decoder #(
  parameter logic [9:0] H_SYNC   = 10'd96,
  parameter logic [9:0] H_BACK   = 10'd48,
  parameter logic [9:0] H_VALID  = 10'd640,
  parameter logic [9:0] H_TOTAL  = 10'd800,
  parameter logic [9:0] V_SYNC   = 10'd2,
  parameter logic [9:0] V_BACK   = 10'd33,
  parameter logic [9:0] V_VALID  = 10'd480,
  parameter logic [9:0] V_TOTAL  = 10'd525,
  parameter logic       SYNC_POL = 1'b1
) (
  input  logic                           vga_clk,
  input  logic                           sys_rst_n,
  input  logic                           hsync,
  input  logic                           vsync,
  input  logic [vga_rx_pkg::RGB_W-1:0]   rgb,
  output logic                           pix_valid,
  output logic [vga_rx_pkg::CNT_W-1:0]   pix_x,
  output logic [vga_rx_pkg::CNT_W-1:0]   pix_y,
  output logic [vga_rx_pkg::RGB_W-1:0]   pix_data,
  output logic                           frame_start,
  output logic                           locked,
  output logic                           timing_err
);
  import vga_rx_pkg::*;

  localparam logic [CNT_W-1:0] H_ACT_LO = CNT_W'(H_SYNC + H_BACK);
  localparam logic [CNT_W-1:0] H_ACT_HI = CNT_W'(H_SYNC + H_BACK + H_VALID - 10'd1);
  localparam logic [CNT_W-1:0] V_ACT_LO = CNT_W'(V_SYNC + V_BACK);
  localparam logic [CNT_W-1:0] V_ACT_HI = CNT_W'(V_SYNC + V_BACK + V_VALID - 10'd1);
  localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL - 10'd1);
  localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOTAL - 10'd1);

  logic             hs_edge_c;
  logic             vs_edge_c;
  logic             fs_c;
  logic             early_c;
  logic             ovf_c;
  logic             vbad_c;
  logic             err_c;
  logic             act_c;
  logic             lock_nx_c;
  logic [RGB_W-1:0] rgb_s1_q;
  logic [RGB_W-1:0] rgb_s2_q;
  logic [CNT_W-1:0] h_q, h_d;
  logic [CNT_W-1:0] v_q, v_d;
  state_e           state_q;
  logic             locked_q;
  logic             terr_q;
  pix_t             pix_q, pix_d;

  vga_sync_edge #(.POL(SYNC_POL)) u_hs_edge (
    .clk_i         (vga_clk),
    .rst_ni        (sys_rst_n),
    .sync_i        (hsync),
    .smp_i         (1'b1),
    .lead_edge_c_o (hs_edge_c)
  );

  // vsync is judged against its level at the previous hsync edge.
  vga_sync_edge #(.POL(SYNC_POL)) u_vs_edge (
    .clk_i         (vga_clk),
    .rst_ni        (sys_rst_n),
    .sync_i        (vsync),
    .smp_i         (hs_edge_c),
    .lead_edge_c_o (vs_edge_c)
  );

  always_comb begin
    fs_c    = hs_edge_c & vs_edge_c;
    early_c = hs_edge_c && (h_q < H_LAST);
    ovf_c   = !hs_edge_c && (h_q == H_LAST);
    vbad_c  = fs_c && (v_q != V_LAST);
    err_c   = early_c | ovf_c | vbad_c;

    // h saturates at H_TOTAL after a missing edge instead of wrapping.
    h_d = hs_edge_c ? '0 : ((h_q == H_TOTAL) ? h_q : h_q + 10'd1);
    v_d = v_q;
    if (fs_c)           v_d = '0;
    else if (hs_edge_c) v_d = v_q + 10'd1;

    lock_nx_c = !err_c && ((state_q == LOCKED) || ((state_q == ACQUIRE) && fs_c));

    act_c = (h_q >= H_ACT_LO) && (h_q <= H_ACT_HI) &&
            (v_q >= V_ACT_LO) && (v_q <= V_ACT_HI);

    pix_d = '0;
    if (act_c) begin
      pix_d.x     = h_q - H_ACT_LO;
      pix_d.y     = v_q - V_ACT_LO;
      pix_d.data  = rgb_s2_q;
      pix_d.valid = lock_nx_c;
      pix_d.sof   = lock_nx_c && (h_q == H_ACT_LO) && (v_q == V_ACT_LO);
    end
  end

  // Datapath: rgb is delayed twice so it lines up with h_q/v_q.
  always_ff @(posedge vga_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      rgb_s1_q <= '0;
      rgb_s2_q <= '0;
      h_q      <= '0;
      v_q      <= '0;
      pix_q    <= '0;
    end else begin
      rgb_s1_q <= rgb;
      rgb_s2_q <= rgb_s1_q;
      h_q      <= h_d;
      v_q      <= v_d;
      pix_q    <= pix_d;
    end
  end

  // Lock FSM; errors seen during ACQUIRE fall back silently.
  always_ff @(posedge vga_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q  <= UNLOCKED;
      locked_q <= 1'b0;
      terr_q   <= 1'b0;
    end else begin
      terr_q   <= 1'b0;
      locked_q <= lock_nx_c;
      unique case (state_q)
        UNLOCKED: if (fs_c) state_q <= ACQUIRE;
        ACQUIRE: begin
          if (err_c)     state_q <= UNLOCKED;
          else if (fs_c) state_q <= LOCKED;
        end
        LOCKED: begin
          if (err_c) begin
            state_q <= UNLOCKED;
            terr_q  <= 1'b1;
          end
        end
        default: state_q <= UNLOCKED;
      endcase
    end
  end

  assign pix_valid   = pix_q.valid;
  assign frame_start = pix_q.sof;
  assign pix_x       = pix_q.x;
  assign pix_y       = pix_q.y;
  assign pix_data    = pix_q.data;
  assign locked      = locked_q;
  assign timing_err  = terr_q;

endmodule

// File: tb/tb_vga_rx_decoder.sv
// Directed bench for vga_rx_decoder on a shrunken raster (20 clocks x 10 lines,
// 8x4 active window starting at h=7, v=4) so whole frames stay short.
module tb_vga_rx_decoder;

  localparam int HS = 4;
  localparam int HT = 20;
  localparam int VS = 2;
  localparam int VT = 10;

  logic        vga_clk;
  logic        sys_rst_n;
  logic        hsync;
  logic        vsync;
  logic [15:0] rgb;
  logic        pix_valid;
  logic [9:0]  pix_x;
  logic [9:0]  pix_y;
  logic [15:0] pix_data;
  logic        frame_start;
  logic        locked;
  logic        timing_err;

  vga_rx_decoder #(
    .H_SYNC(10'd4), .H_BACK(10'd3), .H_VALID(10'd8), .H_TOTAL(10'd20),
    .V_SYNC(10'd2), .V_BACK(10'd2), .V_VALID(10'd4), .V_TOTAL(10'd10),
    .SYNC_POL(1'b1)
  ) dut (
    .vga_clk     (vga_clk),
    .sys_rst_n   (sys_rst_n),
    .hsync       (hsync),
    .vsync       (vsync),
    .rgb         (rgb),
    .pix_valid   (pix_valid),
    .pix_x       (pix_x),
    .pix_y       (pix_y),
    .pix_data    (pix_data),
    .frame_start (frame_start),
    .locked      (locked),
    .timing_err  (timing_err)
  );

  initial vga_clk = 1'b0;
  always #5 vga_clk = ~vga_clk;

  int n_vec = 0;
  int n_bad = 0;
  int n_valid, n_sof, n_err;
  logic [39:0] snap [VT][HT];
  logic [39:0] rst_obs;

  task automatic chk(input string tag, input logic [39:0] got, input logic [39:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [39:0] mk(input logic v, input logic s, input logic l,
                                     input logic t, input logic [9:0] x,
                                     input logic [9:0] y, input logic [15:0] d);
    return {v, s, l, t, x, y, d};
  endfunction

  function automatic logic [39:0] outs();
    return {pix_valid, frame_start, locked, timing_err, pix_x, pix_y, pix_data};
  endfunction

  // Red for the left half of each active line, orange for the right half.
  function automatic logic [15:0] pat(input int ln, input int p);
    if (p >= 7 && p <= 14 && ln >= 4 && ln <= 7)
      return (p - 7 < 4) ? vga_rx_pkg::RGB_RED : vga_rx_pkg::RGB_ORANGE;
    return 16'hAAAA;
  endfunction

  task automatic drive(input int ln, input int p, input bit hs_en);
    hsync = hs_en && (p < HS);
    vsync = (ln < VS);
    rgb   = pat(ln, p);
    @(posedge vga_clk);
    #1;
    n_valid += int'(pix_valid);
    n_sof   += int'(frame_start);
    n_err   += int'(timing_err);
    snap[ln][p] = outs();
  endtask

  task automatic run_frame(input int first_ln, input int short_ln, input int nohs_ln,
                           input int rst_ln, input int rst_p);
    n_valid = 0; n_sof = 0; n_err = 0;
    for (int l = 0; l < VT; l++)
      for (int q = 0; q < HT; q++) snap[l][q] = '0;
    for (int ln = first_ln; ln < VT; ln++) begin
      for (int p = 0; p < ((ln == short_ln) ? HT - 1 : HT); p++) begin
        drive(ln, p, ln != nohs_ln);
        if (ln == rst_ln && p == rst_p) begin
          sys_rst_n = 1'b0;
          #1;
          rst_obs = outs();
        end
        if (ln == rst_ln && p == rst_p + 3) sys_rst_n = 1'b1;
      end
    end
  endtask

  initial begin
    sys_rst_n = 1'b0;
    hsync = 1'b0; vsync = 1'b0; rgb = '0;
    n_valid = 0; n_sof = 0; n_err = 0;

    // Reset held with toggling inputs
    for (int i = 0; i < 6; i++) begin
      drive(i % 3, (i * 3) % HT, 1'b1);
      chk("rst_hold", outs(), '0);
    end
    sys_rst_n = 1'b1;

    // Partial frame then frame A: no strobes, no lock
    run_frame(6, -1, -1, -1, -1);
    chk("partial_valid", 40'(n_valid), 40'd0);
    run_frame(0, -1, -1, -1, -1);
    chk("A_valid", 40'(n_valid), 40'd0);
    chk("A_end", snap[9][19], '0);

    // Frame B: lock rises one clock after the frame-start edge, data checks
    run_frame(0, -1, -1, -1, -1);
    chk("B_p0", snap[0][0], '0);
    chk("B_p1", snap[0][1], mk(0, 0, 1, 0, 0, 0, 0));
    chk("B_pre", snap[4][8], mk(0, 0, 1, 0, 0, 0, 0));
    chk("B_00", snap[4][9], mk(1, 1, 1, 0, 0, 0, 16'hF800));
    chk("B_40", snap[4][13], mk(1, 0, 1, 0, 10'd4, 0, 16'hFC00));
    chk("B_70", snap[4][16], mk(1, 0, 1, 0, 10'd7, 0, 16'hFC00));
    chk("B_post", snap[4][17], mk(0, 0, 1, 0, 0, 0, 0));
    chk("B_73", snap[7][16], mk(1, 0, 1, 0, 10'd7, 10'd3, 16'hFC00));
    chk("B_valid", 40'(n_valid), 40'd32);
    chk("B_sof", 40'(n_sof), 40'd1);
    chk("B_err", 40'(n_err), 40'd0);

    // Frame C: line 5 is one clock short
    run_frame(0, 5, -1, -1, -1);
    chk("C_l6p0", snap[6][0], mk(0, 0, 1, 0, 0, 0, 0));
    chk("C_l6p1", snap[6][1], mk(0, 0, 0, 1, 0, 0, 0));
    chk("C_l6p2", snap[6][2], '0);
    chk("C_valid", 40'(n_valid), 40'd16);
    chk("C_err", 40'(n_err), 40'd1);

    // Frame D re-acquires, frame E locks again
    run_frame(0, -1, -1, -1, -1);
    chk("D_valid", 40'(n_valid), 40'd0);
    chk("D_end", snap[9][19], '0);
    run_frame(0, -1, -1, -1, -1);
    chk("E_valid", 40'(n_valid), 40'd32);

    // Frame F: hsync pulse of line 5 missing, h must saturate
    run_frame(0, -1, 5, -1, -1);
    chk("F_l5p0", snap[5][0], mk(0, 0, 1, 0, 0, 0, 0));
    chk("F_l5p1", snap[5][1], mk(0, 0, 0, 1, 0, 0, 0));
    for (int p = 2; p < HT; p++) chk("F_nowrap", snap[5][p], '0);
    chk("F_valid", 40'(n_valid), 40'd8);
    chk("F_err", 40'(n_err), 40'd1);

    // Frame G acquires, frame H locks and is reset mid-frame
    run_frame(0, -1, -1, -1, -1);
    chk("G_valid", 40'(n_valid), 40'd0);
    run_frame(0, -1, -1, 5, 10);
    chk("H_prerst", snap[5][10], mk(1, 0, 1, 0, 10'd1, 10'd1, 16'hF800));
    chk("H_rst", rst_obs, '0);
    chk("H_valid", 40'(n_valid), 40'd10);

    // Frame I acquires, frame J locks
    run_frame(0, -1, -1, -1, -1);
    chk("I_valid", 40'(n_valid), 40'd0);
    chk("I_err", 40'(n_err), 40'd0);
    chk("I_end", snap[9][19], '0);
    run_frame(0, -1, -1, -1, -1);
    chk("J_p0", snap[0][0], '0);
    chk("J_p1", snap[0][1], mk(0, 0, 1, 0, 0, 0, 0));
    chk("J_valid", 40'(n_valid), 40'd32);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
